// File: rtl/alu_lockstep_sched.sv
// Round-robin scheduler for a dual-lane lockstep ALU: issues identical operands to both
// lanes, waits out the ALU latency, retries on lane mismatch and returns the lane-1 result.
module alu_lockstep_sched #(
  parameter int ALU_LAT   = 1,
  parameter int MAX_RETRY = 1
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [1:0] req_i,
  input  logic [7:0] req_a_i,
  input  logic [7:0] req_b_i,
  input  logic [3:0] req_sel_i,
  output logic [1:0] gnt_o,
  output logic [1:0] done_o,
  output logic [3:0] rsp_result_o,
  output logic       rsp_carry_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  output logic [7:0] err_cnt_o,
  output logic [3:0] alu_a0_o,
  output logic [3:0] alu_b0_o,
  output logic [3:0] alu_a1_o,
  output logic [3:0] alu_b1_o,
  output logic [1:0] alu_sel1_o,
  output logic [1:0] alu_sel2_o,
  input  logic [3:0] alu_out1_i,
  input  logic       alu_carry1_i,
  input  logic [3:0] alu_x_i,
  input  logic       alu_y_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_RESP
  } state_e;

  state_e     state_q;
  logic       last_q;
  logic       win_q;
  logic [1:0] retry_q;
  logic [2:0] wait_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic [3:0] res_q;
  logic       carry_q;
  logic       err_q;
  logic [7:0] err_cnt_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] sel_q;

  logic       win_d;
  logic [3:0] a_d;
  logic [3:0] b_d;
  logic [1:0] sel_d;
  logic       mismatch_d;
  logic       retry_ok_d;

  // A lone requester wins outright; on a tie the one not granted last time wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_d = req_i[1];
    if (req_i == 2'b11) win_d = ~last_q;
    a_d   = win_d ? req_a_i[7:4]   : req_a_i[3:0];
    b_d   = win_d ? req_b_i[7:4]   : req_b_i[3:0];
    sel_d = win_d ? req_sel_i[3:2] : req_sel_i[1:0];
  end

  assign mismatch_d = (|alu_x_i) | alu_y_i;
  assign retry_ok_d = (int'(retry_q) < MAX_RETRY);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      retry_q   <= '0;
      wait_q    <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|req_i) begin
            win_q   <= win_d;
            last_q  <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            retry_q <= '0;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_q  <= 3'(ALU_LAT);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == 3'd1) state_q <= S_CHECK;
          else                wait_q  <= wait_q - 3'd1;
        end
        S_CHECK: begin
          if (mismatch_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          // Retries re-enter ISSUE without a second grant pulse.
          if (mismatch_d && retry_ok_d) begin
            retry_q <= retry_q + 2'd1;
            state_q <= S_ISSUE;
          end else begin
            res_q   <= alu_out1_i;
            carry_q <= alu_carry1_i;
            err_q   <= mismatch_d;
            done_q  <= win_q ? 2'b10 : 2'b01;
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt_o        = gnt_q;
  assign done_o       = done_q;
  assign rsp_result_o = res_q;
  assign rsp_carry_o  = carry_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign err_cnt_o    = err_cnt_q;
  assign alu_a0_o     = a_q;
  assign alu_a1_o     = a_q;
  assign alu_b0_o     = b_q;
  assign alu_b1_o     = b_q;
  assign alu_sel1_o   = sel_q;
  assign alu_sel2_o   = sel_q;

endmodule

// File: doc/alu_lockstep_sched.md
# alu_lockstep_sched

Two-requester scheduler for the dual-lane 4-bit ALU with XOR cross-check. It arbitrates round-robin between two requesters and drives identical operands and select onto both ALU lanes, so the lanes run in lockstep. It waits out the ALU's register latency, then checks the lane-compare outputs, retrying on mismatch. It returns the lane-1 result with an error flag and keeps a saturating mismatch counter. It sits between user-side requesters (IO or LA decode) and the ALU instance inside the user project wrapper.

## Interface
Parameters:
- ALU_LAT, 1, cycles from operands valid at ALU inputs to outputs valid (range 1..7)
- MAX_RETRY, 1, re-issues allowed after a mismatch (range 0..3)

Ports:
- wb_clk_i  in  1  clock, rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_i  in  2  request valid; bit n belongs to requester n
- req_a_i  in  8  operand A; [3:0] is requester 0, [7:4] is requester 1
- req_b_i  in  8  operand B, same packing as req_a_i
- req_sel_i  in  4  ALU select; [1:0] is requester 0, [3:2] is requester 1
- gnt_o  out  2  one-hot grant, 1-cycle pulse
- done_o  out  2  one-hot completion, 1-cycle pulse
- rsp_result_o  out  4  lane-1 ALU result, valid while done_o != 0
- rsp_carry_o  out  1  lane-1 carry, valid while done_o != 0
- rsp_err_o  out  1  mismatch persisted after all retries, valid while done_o != 0
- busy_o  out  1  high in every state except IDLE
- err_cnt_o  out  8  count of mismatching CHECK cycles, saturates at 255
- alu_a0_o, alu_b0_o, alu_a1_o, alu_b1_o  out  4 each  lane operands, registered; lanes always carry identical operands
- alu_sel1_o, alu_sel2_o  out  2 each  lane selects, registered and identical
- alu_out1_i  in  4  lane-1 result
- alu_carry1_i  in  1  lane-1 carry
- alu_x_i  in  4  lane result XOR
- alu_y_i  in  1  lane carry compare

## Operation
- States are IDLE, ISSUE, WAIT, CHECK, RESP.
- **IDLE**
  - On any req_i bit set, pick the winner and latch its A, B and sel.
  - Reset retry count to 0 and go to ISSUE.
  - With no request, stay in IDLE.
- **Arbitration**
  - Round-robin with a last-granted pointer; the pointer resets to 1, so requester 0 wins the first tie.
  - If both request, the requester not last granted wins.
  - If one requests, it wins regardless of the pointer.
  - The pointer updates on grant.
- **ISSUE** (1 cycle)
  - gnt_o[winner]=1 on the first issue only; no grant on retries.
  - alu_*_o carry the latched operands and sel from this cycle until leaving CHECK.
- **WAIT**: lasts ALU_LAT cycles, counted with a 3-bit down-counter, then go to CHECK.
- **CHECK** (1 cycle)
  - mismatch = (|alu_x_i) | alu_y_i.
  - On mismatch, err_cnt_o increments, saturating.
  - Mismatch with retry < MAX_RETRY: retry++, go to ISSUE.
  - Otherwise, capture alu_out1_i, alu_carry1_i and mismatch into response registers, go to RESP.
- **RESP** (1 cycle)
  - done_o[winner]=1 and rsp_* are valid.
  - Go to IDLE. Arbitration resumes in the next cycle, so there are no back-to-back grants.
- **Requester rules**
  - Hold req and operands stable until gnt.
  - Dropping req before grant is legal and produces no transaction.
  - Operands may change after gnt.
  - Keeping req high after done starts a new transaction.
- alu_*_o keep their last values in IDLE; they are not cleared.

## Timing
- **Reset**
  - While wb_rst_i=1 (asynchronous): state=IDLE, every output=0, pointer=1, retry=0, err_cnt=0.
  - Reset mid-transaction aborts it with no done pulse; the requester must re-request.
- **Nominal latency**, taking edge 0 as the IDLE edge that samples req:
  - gnt in cycle 1.
  - ALU inputs valid from cycle 1.
  - WAIT occupies cycles 2..1+ALU_LAT.
  - CHECK in cycle 2+ALU_LAT.
  - done in cycle 3+ALU_LAT; with ALU_LAT=1, done is in cycle 4.
- **Retry**: each retry adds 2+ALU_LAT cycles.
- **Worst case**: done by cycle 3+ALU_LAT+MAX_RETRY*(2+ALU_LAT).
- **Throughput**: one transaction per 4+ALU_LAT cycles when mismatch-free.
- **Simultaneous events**
  - A request arriving during a transaction waits and is never dropped.
  - With both requesting continuously, grants alternate strictly.
  - With MAX_RETRY=0, a mismatch goes straight to RESP with rsp_err_o=1.

## Test plan
- **Single request**: req_i=01, A=3, B=5, sel=00, ALU model out1=8, no mismatch, ALU_LAT=1. Expect gnt_o=01 in cycle 1, alu_a0=alu_a1=3 and alu_b0=alu_b1=5 from cycle 1, done_o=01 in cycle 4 with result=8, carry=0, err=0, err_cnt=0.
- **Arbitration fairness**: both req high continuously from reset. Expect grant sequence 01,10,01,10 with each grant 5 cycles apart and done order matching grant order.
- **Transient mismatch**: x=4'b0001 on the first CHECK only, ALU_LAT=1. Expect one re-issue with no second gnt, done in cycle 7, err=0, err_cnt=1.
- **Persistent mismatch**: y=1 on every CHECK, MAX_RETRY=1. Expect done in cycle 7 with err=1 and err_cnt=2; with MAX_RETRY=0, expect done in cycle 4 with err=1.
- **Reset in WAIT**: assert wb_rst_i mid-cycle while in WAIT. Expect all outputs 0 immediately, no done pulse; after release, with req held, a fresh gnt one cycle later.
- **Counter saturation**: 300 transactions with persistent mismatch and MAX_RETRY=0. Expect err_cnt_o to reach 255 and hold.
